// File: rtl/issue_unit.sv
// Single-issue arbiter for the integer, load/store, multiply and divide
// issue queues. Grants at most one read enable per cycle, reserves future
// CDB write slots so results never collide, and tracks occupancy of the
// non-pipelined divider.
//
// Handshake: iq_*_rdy is a valid indication from a queue; iu_*_r_en is the
// same-cycle ready/accept. The queue presents its entry while r_en is high
// and drops it at the following posedge. There is no back-pressure beyond
// the grant itself.
module issue_unit #(
   parameter int INT_LAT = 1,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic cdb_flush,
   input  logic iq_int_rdy,
   input  logic iq_ldst_rdy,
   input  logic iq_mul_rdy,
   input  logic iq_div_rdy,
   output logic iu_int_r_en,
   output logic iu_ldst_r_en,
   output logic iu_mul_r_en,
   output logic iu_div_r_en,
   output logic iu_div_busy
);

   if (!(INT_LAT >= 1 && INT_LAT < MUL_LAT && MUL_LAT < DIV_LAT && DIV_LAT <= 15)) begin : g_bad_lat
      $error("issue_unit: latencies must satisfy 1 <= INT_LAT < MUL_LAT < DIV_LAT <= 15");
   end

   // cdb_busy[k] = CDB write already claimed k cycles after the current one
   logic [DIV_LAT:1] cdb_busy;
   logic [DIV_LAT:1] cdb_busy_next;
   logic [3:0]       div_cnt;
   logic             lru;        // 0 = integer preferred, 1 = load/store preferred

   logic div_ok, mul_ok, int_ok, ldst_ok;
   logic grant_int, grant_ldst, grant_mul, grant_div;

   assign div_ok  = iq_div_rdy & (div_cnt == 4'd0) & ~cdb_busy[DIV_LAT];
   assign mul_ok  = iq_mul_rdy & ~cdb_busy[MUL_LAT];
   assign int_ok  = iq_int_rdy & ~cdb_busy[INT_LAT];
   assign ldst_ok = iq_ldst_rdy;

   // Fixed priority div > mul > {int, ldst}; int/ldst tie broken by lru.
   // Reset and flush suppress every grant.
   always_comb begin
      grant_int  = 1'b0;
      grant_ldst = 1'b0;
      grant_mul  = 1'b0;
      grant_div  = 1'b0;
      if (!reset && !cdb_flush) begin
         if (div_ok) begin
            grant_div = 1'b1;
         end else if (mul_ok) begin
            grant_mul = 1'b1;
         end else if (int_ok && ldst_ok) begin
            if (lru) grant_ldst = 1'b1;
            else     grant_int  = 1'b1;
         end else if (int_ok) begin
            grant_int = 1'b1;
         end else if (ldst_ok) begin
            grant_ldst = 1'b1;
         end
      end
   end

   // Shift the slot map one cycle closer and add the new claim at bit L-1.
   // A latency-1 op writes next cycle, which the shift has already consumed.
   always_comb begin
      cdb_busy_next = '0;
      for (int k = 1; k < DIV_LAT; k++) begin
         cdb_busy_next[k] = cdb_busy[k+1]
                          | (grant_int && (INT_LAT == k + 1))
                          | (grant_mul && (MUL_LAT == k + 1))
                          | (grant_div && (DIV_LAT == k + 1));
      end
   end

   // State registers: slot map, divider countdown and int/ldst fairness bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         cdb_busy <= '0;
         div_cnt  <= 4'd0;
         lru      <= 1'b0;
      end else begin
         cdb_busy <= cdb_busy_next;
         if (grant_div)              div_cnt <= 4'(DIV_LAT - 1);
         else if (div_cnt != 4'd0)   div_cnt <= div_cnt - 4'd1;
         if (grant_int)              lru <= 1'b1;
         else if (grant_ldst)        lru <= 1'b0;
      end
   end

   assign iu_int_r_en  = grant_int;
   assign iu_ldst_r_en = grant_ldst;
   assign iu_mul_r_en  = grant_mul;
   assign iu_div_r_en  = grant_div;
   assign iu_div_busy  = ~reset & (div_cnt != 4'd0);

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed scenarios followed by random traffic,
// checked against a cycle-indexed reference model of CDB claims.
module tb_issue_unit;
   localparam int INT_LAT = 1;
   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 7;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cdb_flush = 1'b0;
   logic iq_int_rdy = 1'b0, iq_ldst_rdy = 1'b0, iq_mul_rdy = 1'b0, iq_div_rdy = 1'b0;
   logic iu_int_r_en, iu_ldst_r_en, iu_mul_r_en, iu_div_r_en, iu_div_busy;

   issue_unit #(.INT_LAT(INT_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .reset(reset), .cdb_flush(cdb_flush),
      .iq_int_rdy(iq_int_rdy), .iq_ldst_rdy(iq_ldst_rdy),
      .iq_mul_rdy(iq_mul_rdy), .iq_div_rdy(iq_div_rdy),
      .iu_int_r_en(iu_int_r_en), .iu_ldst_r_en(iu_ldst_r_en),
      .iu_mul_r_en(iu_mul_r_en), .iu_div_r_en(iu_div_r_en),
      .iu_div_busy(iu_div_busy)
   );

   // clock
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   // reference model: absolute cycle numbers
   int   cyc = 0;
   bit   claimed[int];
   int   last_div = -100;
   logic lru_m = 1'b0;
   // observed DUT behaviour
   bit   written[int];
   int   last_act_div = -100;
   logic [4:0] act;                 // {busy, div, mul, ldst, int}
   logic [4:0] exp_q[$];

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
   endtask

   // One cycle: drive at negedge, predict, sample 1ns later, update model.
   task automatic step(input logic rst, input logic fl, input logic ri, input logic rl,
                       input logic rm, input logic rd, input string tag);
      logic [3:0] g;
      logic d_ok, m_ok, i_ok, busy;
      @(negedge clk);
      reset = rst; cdb_flush = fl;
      iq_int_rdy = ri; iq_ldst_rdy = rl; iq_mul_rdy = rm; iq_div_rdy = rd;
      g    = 4'b0000;
      d_ok = rd && (cyc - last_div >= DIV_LAT) && !claimed.exists(cyc + DIV_LAT);
      m_ok = rm && !claimed.exists(cyc + MUL_LAT);
      i_ok = ri && !claimed.exists(cyc + INT_LAT);
      if (!rst && !fl) begin
         if (d_ok)              g = 4'b1000;
         else if (m_ok)         g = 4'b0100;
         else if (i_ok && rl)   g = lru_m ? 4'b0010 : 4'b0001;
         else if (i_ok)         g = 4'b0001;
         else if (rl)           g = 4'b0010;
      end
      busy = !rst && (cyc - last_div >= 1) && (cyc - last_div < DIV_LAT);
      exp_q.push_back({busy, g});
      #1;
      act = {iu_div_busy, iu_div_r_en, iu_mul_r_en, iu_ldst_r_en, iu_int_r_en};
      check(tag, act, exp_q.pop_front());
      check({tag, "_onehot"}, {4'b0, 1'($onehot0(act[3:0]))}, 5'd1);
      if (rst) begin
         written.delete();
         last_act_div = -100;
      end else begin
         if (act[3]) begin
            check({tag, "_div_space"}, {4'b0, 1'(cyc - last_act_div >= DIV_LAT)}, 5'd1);
            check({tag, "_dup_cdb"}, {4'b0, 1'(written.exists(cyc + DIV_LAT))}, 5'd0);
            written[cyc + DIV_LAT] = 1'b1;
            last_act_div = cyc;
         end
         if (act[2]) begin
            check({tag, "_dup_cdb"}, {4'b0, 1'(written.exists(cyc + MUL_LAT))}, 5'd0);
            written[cyc + MUL_LAT] = 1'b1;
         end
         if (act[0]) begin
            check({tag, "_dup_cdb"}, {4'b0, 1'(written.exists(cyc + INT_LAT))}, 5'd0);
            written[cyc + INT_LAT] = 1'b1;
         end
      end
      if (rst) begin
         claimed.delete();
         last_div = -100;
         lru_m = 1'b0;
      end else begin
         if (g[0]) begin claimed[cyc + INT_LAT] = 1'b1; lru_m = 1'b1; end
         if (g[1]) lru_m = 1'b0;
         if (g[2]) claimed[cyc + MUL_LAT] = 1'b1;
         if (g[3]) begin claimed[cyc + DIV_LAT] = 1'b1; last_div = cyc; end
      end
      cyc++;
   endtask

   initial begin
      // reset then idle: div wins, then busy for DIV_LAT-1 cycles
      step(1, 0, 1, 1, 1, 1, "rst_all_rdy");
      check("rst_all_rdy_dir", act, 5'b00000);
      step(0, 0, 1, 1, 1, 1, "first_div");
      check("first_div_dir", act, 5'b01000);
      for (int i = 0; i < DIV_LAT - 1; i++) begin
         step(0, 0, 0, 0, 0, 0, "div_busy");
         check("div_busy_dir", act, 5'b10000);
      end
      step(0, 0, 0, 0, 0, 0, "div_done");
      check("div_done_dir", act, 5'b00000);

      // mul/int collision, with and without ldst as fallback
      step(1, 0, 0, 0, 0, 0, "rst");
      step(0, 0, 0, 0, 1, 0, "mul_t0");
      check("mul_t0_dir", act, 5'b00100);
      step(0, 0, 0, 0, 0, 0, "idle");
      step(0, 0, 0, 0, 0, 0, "idle");
      step(0, 0, 1, 1, 0, 0, "coll_ldst");
      check("coll_ldst_dir", act, 5'b00010);
      step(0, 0, 1, 0, 0, 0, "int_t4");
      check("int_t4_dir", act, 5'b00001);
      step(0, 0, 0, 0, 1, 0, "mul_t0b");
      step(0, 0, 0, 0, 0, 0, "idle");
      step(0, 0, 0, 0, 0, 0, "idle");
      step(0, 0, 1, 0, 0, 0, "coll_none");
      check("coll_none_dir", act, 5'b00000);
      step(0, 0, 1, 0, 0, 0, "int_t4b");
      check("int_t4b_dir", act, 5'b00001);

      // int/ldst alternation from lru = 0
      step(1, 0, 0, 0, 0, 0, "rst");
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 1, 1, 0, 0, "alt");
         check("alt_dir", act, (i % 2 == 0) ? 5'b00001 : 5'b00010);
      end

      // divider back-to-back
      step(1, 0, 0, 0, 0, 0, "rst");
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 0, 0, 1, "div_b2b");
         check("div_b2b_dir", act, (i == 0 || i == 7) ? 5'b01000 : 5'b10000);
      end

      // flush: no grants, but the earlier mul claim still blocks int
      step(1, 0, 0, 0, 0, 0, "rst");
      step(0, 0, 0, 0, 1, 0, "fl_mul");
      check("fl_mul_dir", act, 5'b00100);
      step(0, 0, 0, 0, 0, 0, "idle");
      step(0, 1, 1, 1, 1, 1, "flush");
      check("flush_dir", act, 5'b00000);
      step(0, 0, 1, 0, 0, 0, "fl_int_blk");
      check("fl_int_blk_dir", act, 5'b00000);
      step(0, 0, 1, 0, 0, 0, "fl_int_ok");
      check("fl_int_ok_dir", act, 5'b00001);

      // reset in the middle of a divide clears the divider
      step(0, 0, 0, 0, 0, 1, "mid_div");
      check("mid_div_dir", act, 5'b01000);
      step(0, 0, 0, 0, 0, 0, "idle");
      step(1, 0, 0, 0, 0, 1, "mid_rst");
      check("mid_rst_dir", act, 5'b00000);
      step(0, 0, 0, 0, 0, 1, "post_rst_div");
      check("post_rst_div_dir", act, 5'b01000);

      // random stress
      for (int i = 0; i < 10000; i++) begin
         step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
